// File: rtl/l1_refill_ctrl.sv
// rtl/l1_refill_ctrl.sv - L1 line refill controller: victim writeback, line read, fill and tag update
// L1_REFILL_CRIT_WORD_EN returns the requested word in the cycle its beat arrives instead of in TAG.
`ifndef L1_WAY_NUM
`define L1_WAY_NUM 4
`endif

module l1_refill_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BEAT_NUM   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           miss_val,
  input  logic [ADDR_WIDTH-1:0]          miss_addr,
  input  logic [`L1_WAY_NUM-1:0]         way_vect,
  input  logic                           evict_val,
  input  logic [ADDR_WIDTH-1:0]          evict_addr,
  input  logic [BEAT_NUM*DATA_WIDTH-1:0] evict_data,
  output logic                           busy,
  output logic                           mem_req_val,
  output logic                           mem_req_we,
  output logic [ADDR_WIDTH-1:0]          mem_req_addr,
  output logic [DATA_WIDTH-1:0]          mem_req_wdata,
  input  logic                           mem_req_ack,
  input  logic                           mem_resp_val,
  input  logic [DATA_WIDTH-1:0]          mem_resp_data,
  output logic                           fill_we,
  output logic [`L1_WAY_NUM-1:0]         fill_way,
  output logic [ADDR_WIDTH-1:0]          fill_addr,
  output logic [DATA_WIDTH-1:0]          fill_data,
  output logic                           tag_we,
  output logic                           core_resp_val,
  output logic [DATA_WIDTH-1:0]          core_resp_data
);

  localparam int BW  = $clog2(BEAT_NUM);
  localparam int OFF = BW + 2;
  localparam int TW  = ADDR_WIDTH - OFF;

  typedef enum logic [2:0] {S_IDLE, S_WB, S_RD, S_RESP, S_TAG} state_t;

  state_t                        state_q, state_d;
  logic [BW-1:0]                 beat_q, beat_d;
  logic [BW-1:0]                 crit_idx_q, crit_idx_d;
  logic [TW-1:0]                 miss_line_q, miss_line_d;
  logic [TW-1:0]                 evict_line_q, evict_line_d;
  logic [`L1_WAY_NUM-1:0]        way_q, way_d;
  logic [BEAT_NUM*DATA_WIDTH-1:0] evict_data_q, evict_data_d;
`ifndef L1_REFILL_CRIT_WORD_EN
  logic [DATA_WIDTH-1:0]         crit_word_q, crit_word_d;
`endif

  logic [ADDR_WIDTH-1:0] miss_base;
  logic [ADDR_WIDTH-1:0] evict_base;
  logic [ADDR_WIDTH-1:0] beat_off;
  logic                  last_beat;
  logic                  unused_addr_bits;

  assign miss_base        = {miss_line_q, {OFF{1'b0}}};
  assign evict_base       = {evict_line_q, {OFF{1'b0}}};
  assign beat_off         = ADDR_WIDTH'({beat_q, 2'b00});
  assign last_beat        = (beat_q == BW'(BEAT_NUM - 1));
  assign unused_addr_bits = ^{miss_addr[1:0], evict_addr[OFF-1:0]};

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    crit_idx_d     = crit_idx_q;
    miss_line_d    = miss_line_q;
    evict_line_d   = evict_line_q;
    way_d          = way_q;
    evict_data_d   = evict_data_q;
`ifndef L1_REFILL_CRIT_WORD_EN
    crit_word_d    = crit_word_q;
`endif
    busy           = (state_q != S_IDLE);
    mem_req_val    = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;
    fill_we        = 1'b0;
    fill_way       = '0;
    fill_addr      = '0;
    fill_data      = '0;
    tag_we         = 1'b0;
    core_resp_val  = 1'b0;
    core_resp_data = '0;

    case (state_q)
      S_IDLE: begin
        if (miss_val) begin
          miss_line_d  = miss_addr[ADDR_WIDTH-1:OFF];
          crit_idx_d   = miss_addr[OFF-1:2];
          evict_line_d = evict_addr[ADDR_WIDTH-1:OFF];
          way_d        = way_vect;
          evict_data_d = evict_data;
          beat_d       = '0;
          state_d      = evict_val ? S_WB : S_RD;
        end
      end
      S_WB: begin
        // Request fields depend only on state and beat, so they hold while ack is low.
        mem_req_val   = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = evict_base | beat_off;
        mem_req_wdata = evict_data_q[beat_q*DATA_WIDTH +: DATA_WIDTH];
        if (mem_req_ack) begin
          beat_d = last_beat ? '0 : beat_q + BW'(1);
          if (last_beat) state_d = S_RD;
        end
      end
      S_RD: begin
        mem_req_val  = 1'b1;
        mem_req_addr = miss_base;
        if (mem_req_ack) begin
          beat_d  = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (mem_resp_val) begin
          fill_we   = 1'b1;
          fill_way  = way_q;
          fill_addr = miss_base | beat_off;
          fill_data = mem_resp_data;
          if (beat_q == crit_idx_q) begin
`ifdef L1_REFILL_CRIT_WORD_EN
            core_resp_val  = 1'b1;
            core_resp_data = mem_resp_data;
`else
            crit_word_d    = mem_resp_data;
`endif
          end
          beat_d = last_beat ? '0 : beat_q + BW'(1);
          if (last_beat) state_d = S_TAG;
        end
      end
      S_TAG: begin
        tag_we    = 1'b1;
        fill_way  = way_q;
        fill_addr = miss_base;
`ifndef L1_REFILL_CRIT_WORD_EN
        core_resp_val  = 1'b1;
        core_resp_data = crit_word_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      crit_idx_q   <= '0;
      miss_line_q  <= '0;
      evict_line_q <= '0;
      way_q        <= '0;
      evict_data_q <= '0;
`ifndef L1_REFILL_CRIT_WORD_EN
      crit_word_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      crit_idx_q   <= crit_idx_d;
      miss_line_q  <= miss_line_d;
      evict_line_q <= evict_line_d;
      way_q        <= way_d;
      evict_data_q <= evict_data_d;
`ifndef L1_REFILL_CRIT_WORD_EN
      crit_word_q  <= crit_word_d;
`endif
    end
  end

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// tb/tb_l1_refill_ctrl.sv - randomized refill bench with a transaction-level reference model
`ifndef L1_WAY_NUM
`define L1_WAY_NUM 4
`endif

module tb_l1_refill_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BN = 4;
  localparam int WN = `L1_WAY_NUM;

  logic            clk, rst;
  logic            miss_val;
  logic [AW-1:0]   miss_addr;
  logic [WN-1:0]   way_vect;
  logic            evict_val;
  logic [AW-1:0]   evict_addr;
  logic [BN*DW-1:0] evict_data;
  logic            busy;
  logic            mem_req_val, mem_req_we, mem_req_ack;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_wdata;
  logic            mem_resp_val;
  logic [DW-1:0]   mem_resp_data;
  logic            fill_we, tag_we, core_resp_val;
  logic [WN-1:0]   fill_way;
  logic [AW-1:0]   fill_addr;
  logic [DW-1:0]   fill_data, core_resp_data;

  l1_refill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEAT_NUM(BN)) dut (
    .clk(clk), .rst(rst), .miss_val(miss_val), .miss_addr(miss_addr), .way_vect(way_vect),
    .evict_val(evict_val), .evict_addr(evict_addr), .evict_data(evict_data), .busy(busy),
    .mem_req_val(mem_req_val), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_ack(mem_req_ack), .mem_resp_val(mem_resp_val),
    .mem_resp_data(mem_resp_data), .fill_we(fill_we), .fill_way(fill_way), .fill_addr(fill_addr),
    .fill_data(fill_data), .tag_we(tag_we), .core_resp_val(core_resp_val),
    .core_resp_data(core_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] line_of(input logic [31:0] x);
    return x & ~32'(BN * 4 - 1);
  endfunction

  // Observed transactions; the main thread only reads these, using start indices per miss.
  logic [63:0]    wr_q[$];
  logic [31:0]    rd_q[$];
  logic [WN+63:0] fill_q[$];
  logic [WN+31:0] tag_q[$];
  logic [35:0]    core_q[$];

  int           ack_delay = 0;
  logic [127:0] cur_resp  = '0;
  logic [31:0]  rq[$];
  int           gap = 0;
  int           wcnt = 0;
  bit           pend = 0;
  bit           tag_prev = 0;
  logic [31:0]  p_addr, p_wdata;
  logic         p_we;

  // Memory model and output monitor: drive away from posedge, then sample the settled cycle.
  always @(negedge clk) begin
    if (rst) begin
      wcnt = 0;
      mem_req_ack = 1'b0;
    end else if (mem_req_val && wcnt < ack_delay) begin
      mem_req_ack = 1'b0;
      wcnt++;
    end else begin
      mem_req_ack = mem_req_val;
      wcnt = 0;
    end
    if (rq.size() > 0 && gap == 0) begin
      mem_resp_val  = 1'b1;
      mem_resp_data = rq.pop_front();
      gap = $urandom_range(0, 2);
    end else begin
      mem_resp_val  = 1'b0;
      mem_resp_data = $urandom;
      if (gap > 0) gap--;
    end
    #1;
    if (rst) begin
      pend = 0;
      tag_prev = 0;
    end else begin
      if (pend) begin
        check_eq("req_val_hold", mem_req_val, 1'b1);
        check_eq("req_addr_hold", mem_req_addr, p_addr);
        check_eq("req_wdata_hold", mem_req_wdata, p_wdata);
        check_eq("req_we_hold", mem_req_we, p_we);
      end
      pend    = mem_req_val && !mem_req_ack;
      p_addr  = mem_req_addr;
      p_wdata = mem_req_wdata;
      p_we    = mem_req_we;
      if (mem_req_val && mem_req_ack) begin
        if (mem_req_we) wr_q.push_back({mem_req_addr, mem_req_wdata});
        else begin
          rd_q.push_back(mem_req_addr);
          for (int i = 0; i < BN; i++) rq.push_back(cur_resp[32*i +: 32]);
          gap = 1 + $urandom_range(0, 2);
        end
      end
      if (fill_we) fill_q.push_back({fill_way, fill_addr, fill_data});
      if (tag_prev) check_eq("busy_after_tag", busy, 1'b0);
      if (tag_we) begin
        tag_q.push_back({fill_way, fill_addr});
        check_eq("busy_in_tag", busy, 1'b1);
      end
      tag_prev = tag_we;
      if (core_resp_val) core_q.push_back({fill_we, tag_we, fill_addr[3:2], core_resp_data});
    end
  end

  function automatic logic [255:0] all_outputs();
    return {busy, mem_req_val, mem_req_we, mem_req_addr, mem_req_wdata, fill_we, fill_way,
            fill_addr, fill_data, tag_we, core_resp_val, core_resp_data};
  endfunction

  task automatic run_miss(input logic [31:0] a, input logic [WN-1:0] w, input logic ev,
                          input logic [31:0] ea, input logic [127:0] ed, input logic [127:0] rsp,
                          input int ackd, input bit spam);
    int bw, br, bf, bt, bc, ci;
    bit done;
    bw = wr_q.size(); br = rd_q.size(); bf = fill_q.size(); bt = tag_q.size(); bc = core_q.size();
    done = 0;
    ack_delay = ackd;
    cur_resp  = rsp;
    @(posedge clk); #1;
    rst = 1'b0;
    miss_val = 1'b1; miss_addr = a; way_vect = w;
    evict_val = ev; evict_addr = ea; evict_data = ed;
    @(posedge clk); #1;
    if (spam) begin
      miss_addr = 32'h3000;
      evict_val = 1'b1;
    end else miss_val = 1'b0;
    @(negedge clk); #2;
    check_eq("busy_rise", busy, 1'b1);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk); #2;
      if (tag_we) miss_val = 1'b0;
      if (!busy) begin
        done = 1;
        break;
      end
    end
    miss_val = 1'b0;
    check_eq("miss_done", done, 1'b1);

    check_eq("n_wr", wr_q.size() - bw, ev ? BN : 0);
    if (ev)
      for (int i = 0; i < BN && bw + i < wr_q.size(); i++)
        check_eq($sformatf("wr%0d", i), wr_q[bw+i], {line_of(ea) + 32'(4*i), ed[32*i +: 32]});
    check_eq("n_rd", rd_q.size() - br, 1);
    if (rd_q.size() > br) check_eq("rd_addr", rd_q[br], line_of(a));
    check_eq("n_fill", fill_q.size() - bf, BN);
    for (int i = 0; i < BN && bf + i < fill_q.size(); i++)
      check_eq($sformatf("fill%0d", i), fill_q[bf+i], {w, line_of(a) + 32'(4*i), rsp[32*i +: 32]});
    check_eq("n_tag", tag_q.size() - bt, 1);
    if (tag_q.size() > bt) check_eq("tag", tag_q[bt], {w, line_of(a)});
    ci = int'((a >> 2) & 32'(BN - 1));
    check_eq("n_core", core_q.size() - bc, 1);
    if (core_q.size() > bc) begin
`ifdef L1_REFILL_CRIT_WORD_EN
      check_eq("core", core_q[bc], {1'b1, 1'b0, 2'(ci), rsp[32*ci +: 32]});
`else
      check_eq("core", core_q[bc], {1'b0, 1'b1, 2'b00, rsp[32*ci +: 32]});
`endif
    end
  endtask

  initial begin
    int bf, bt, bc;
    bit hit;
    rst = 1'b1; miss_val = 1'b0; miss_addr = '0; way_vect = '0;
    evict_val = 1'b0; evict_addr = '0; evict_data = '0;
    mem_req_ack = 1'b0; mem_resp_val = 1'b0; mem_resp_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    check_eq("reset_outputs", all_outputs(), '0);

    // Clean miss issued in the first cycle after reset release.
    run_miss(32'h1048, 4'b0010, 1'b0, '0, '0, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, 0);
    // Dirty miss.
    run_miss(32'h1234, 4'b0100, 1'b1, 32'h2000, {32'hD3, 32'hD2, 32'hD1, 32'hD0},
             {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 0, 0);
    // Backpressure: ack held low 3 cycles on every request.
    run_miss(32'h5bc4, 4'b1000, 1'b1, 32'h600c, {32'hE3, 32'hE2, 32'hE1, 32'hE0},
             {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 3, 0);
    // Miss request held high while busy must be ignored.
    run_miss(32'h7008, 4'b0001, 1'b0, '0, '0, {32'h13, 32'h12, 32'h11, 32'h10}, 1, 1);

    // Reset in the middle of RESP, then a normal miss.
    ack_delay = 0;
    cur_resp  = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
    bf = fill_q.size();
    hit = 0;
    @(posedge clk); #1;
    miss_val = 1'b1; miss_addr = 32'h5010; way_vect = 4'b0001; evict_val = 1'b0;
    @(posedge clk); #1;
    miss_val = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk); #2;
      if (fill_q.size() >= bf + 2) begin
        hit = 1;
        break;
      end
    end
    check_eq("reach_beat1", hit, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #2;
    check_eq("rst_mid_resp_outputs", all_outputs(), '0);
    bf = fill_q.size(); bt = tag_q.size(); bc = core_q.size();
    repeat (20) @(negedge clk);
    #2;
    check_eq("late_resp_no_fill", fill_q.size() - bf, 0);
    check_eq("late_resp_no_tag", tag_q.size() - bt, 0);
    check_eq("late_resp_no_core", core_q.size() - bc, 0);
    check_eq("idle_after_rst", busy, 1'b0);
    run_miss(32'h4000, 4'b0100, 1'b0, '0, '0, {32'h43, 32'h42, 32'h41, 32'h40}, 0, 0);

    for (int k = 0; k < 30; k++) begin
      logic [127:0] ed, rsp;
      ed  = {$urandom, $urandom, $urandom, $urandom};
      rsp = {$urandom, $urandom, $urandom, $urandom};
      run_miss($urandom, WN'(1) << $urandom_range(0, WN - 1), 1'($urandom_range(0, 1)),
               $urandom, ed, rsp, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
